// File: rtl/dma_ch_reg_slave.sv
// dma_ch_reg_slave
//   Multi-channel DMA register slave. Each channel has SRC/DST/LEN/CTRL
//   registers and a transfer countdown. Every access is accepted with no
//   backpressure. Reads, and any access that errors, return a response
//   {rvalid, err, rdata} RD_LAT cycles after the accepting edge.
//
//   Register map (channel c base = c*0x10, addr[1:0] ignored):
//     +0x0 SRC  RW32
//     +0x4 DST  RW32
//     +0x8 LEN  RW[15:0]
//     +0xC CTRL b0 START (write 1 to start, reads 0), b1 BUSY (RO),
//               b2 DONE (write 1 to clear), b3 IE (RW), b31:16 REMAIN (RO)
//
//   Channel state | meaning
//   --------------+-----------------------------------------------------
//   ST_IDLE       | no transfer; REMAIN is 0; START with LEN!=0 enters RUN
//   ST_RUN        | busy; REMAIN counts down, DONE is set on the 1->0 step
//
// Ports
//   clk            single clock, posedge
//   reset          asynchronous, active-low
//   addr/wr_en/valid/wdata   bus request
//   rdata/rvalid/err         delayed response
//   busy[NUM_CH]   per-channel transfer active
//   irq[NUM_CH]    per-channel DONE & IE (level)
module dma_ch_reg_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] irq
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_CH * 16);
  localparam logic [1:0] OFF_SRC  = 2'd0;
  localparam logic [1:0] OFF_DST  = 2'd1;
  localparam logic [1:0] OFF_LEN  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  ch_state_t   r_state  [NUM_CH];
  logic [31:0] r_src    [NUM_CH];
  logic [31:0] r_dst    [NUM_CH];
  logic [15:0] r_len    [NUM_CH];
  logic [15:0] r_remain [NUM_CH];
  logic        r_done   [NUM_CH];
  logic        r_ie     [NUM_CH];

  logic              r_pv [RD_LAT];
  logic              r_pe [RD_LAT];
  logic [DATA_W-1:0] r_pd [RD_LAT];

  logic              w_in_range;
  logic [3:0]        w_ch;
  logic [1:0]        w_off;
  logic              w_sel_busy;
  logic [31:0]       w_sel_rd;
  logic              w_bad;
  logic              w_wr_ok;
  logic              w_rd;
  logic [DATA_W-1:0] w_rd_resp;
  logic              w_unused;

  assign w_in_range = (addr < ADDR_LIMIT);
  assign w_ch       = addr[7:4];
  assign w_off      = addr[3:2];
  // Byte-lane bits and data bits above the 32-bit registers carry no meaning.
  assign w_unused   = ^{addr[1:0], wdata};

  always_comb begin
    w_sel_busy = 1'b0;
    w_sel_rd   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 4'(c)) begin
        w_sel_busy = (r_state[c] == ST_RUN);
        case (w_off)
          OFF_SRC: w_sel_rd = r_src[c];
          OFF_DST: w_sel_rd = r_dst[c];
          OFF_LEN: w_sel_rd = {16'h0, r_len[c]};
          default: w_sel_rd = {((r_state[c] == ST_RUN) ? r_remain[c] : 16'h0), 12'h0,
                               r_ie[c], r_done[c], (r_state[c] == ST_RUN), 1'b0};
        endcase
      end
    end
  end

  // A busy channel only locks its SRC/DST/LEN; CTRL stays writable so IE and
  // DONE can be managed mid-transfer.
  assign w_bad     = valid & (~w_in_range | (wr_en & (w_off != OFF_CTRL) & w_sel_busy));
  assign w_wr_ok   = valid & wr_en & ~w_bad;
  assign w_rd      = valid & ~wr_en;
  assign w_rd_resp = (w_rd & ~w_bad) ? DATA_W'(w_sel_rd) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]  <= ST_IDLE;
        r_src[c]    <= '0;
        r_dst[c]    <= '0;
        r_len[c]    <= '0;
        r_remain[c] <= '0;
        r_done[c]   <= 1'b0;
        r_ie[c]     <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_ok && (w_ch == 4'(c))) begin
          case (w_off)
            OFF_SRC: r_src[c] <= wdata[31:0];
            OFF_DST: r_dst[c] <= wdata[31:0];
            OFF_LEN: r_len[c] <= wdata[15:0];
            default: begin
              r_ie[c] <= wdata[3];
              if (wdata[2]) begin
                r_done[c] <= 1'b0;
              end
              if (wdata[0] && (r_state[c] == ST_IDLE)) begin
                if (r_len[c] != 16'h0) begin
                  r_state[c]  <= ST_RUN;
                  r_remain[c] <= r_len[c];
                end else begin
                  r_done[c] <= 1'b1;
                end
              end
            end
          endcase
        end
        // Placed after the CTRL write so a completion overrides a same-cycle
        // DONE clear.
        if (r_state[c] == ST_RUN) begin
          r_remain[c] <= r_remain[c] - 16'd1;
          if (r_remain[c] == 16'd1) begin
            r_state[c] <= ST_IDLE;
            r_done[c]  <= 1'b1;
          end
        end
      end
    end
  end

  // Response pipe: stage 0 captures at the accepting edge, the last stage
  // drives the outputs. Non-read, non-error cycles load zeros, so rdata is 0
  // whenever rvalid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd;
      r_pe[0] <= w_bad;
      r_pd[0] <= w_rd_resp;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign rvalid = r_pv[RD_LAT-1];
  assign err    = r_pe[RD_LAT-1];
  assign rdata  = r_pd[RD_LAT-1];

  always_comb begin
    busy = '0;
    irq  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c] = (r_state[c] == ST_RUN);
      irq[c]  = r_done[c] & r_ie[c];
    end
  end

endmodule

// File: tb/tb_dma_ch_reg_slave.sv
module tb_dma_ch_reg_slave;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int RD_LAT = 2;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic              wr_en = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] irq;

  always #5 clk = ~clk;

  dma_ch_reg_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .RD_LAT(RD_LAT)
  ) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .valid(valid),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err),
    .busy(busy), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a transfer is described by the edge number at which it
  // completes (m_end); busy and REMAIN follow from plain arithmetic on m_t.
  int unsigned m_t;
  logic [31:0] m_src [NUM_CH];
  logic [31:0] m_dst [NUM_CH];
  logic [15:0] m_len [NUM_CH];
  bit          m_done[NUM_CH];
  bit          m_ie  [NUM_CH];
  int unsigned m_end [NUM_CH];

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } resp_t;
  resp_t m_pipe[$];

  logic              e_rvalid, e_err;
  logic [DATA_W-1:0] e_rdata;
  logic [NUM_CH-1:0] e_busy, e_irq;

  function automatic bit m_busy_pre(int c);
    return m_t <= m_end[c];
  endfunction

  function automatic logic [31:0] m_read(int c, int off);
    int unsigned rem;
    rem = m_busy_pre(c) ? (m_end[c] - m_t + 1) : 0;
    case (off)
      0: return m_src[c];
      1: return m_dst[c];
      2: return {16'h0, m_len[c]};
      default: return {rem[15:0], 12'h0, m_ie[c], m_done[c], m_busy_pre(c), 1'b0};
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_len[c] = '0;
      m_done[c] = 0; m_ie[c] = 0; m_end[c] = 0;
    end
    m_pipe.delete();
    for (int i = 0; i < RD_LAT; i++) m_pipe.push_back('0);
    e_rvalid = 0; e_err = 0; e_rdata = '0; e_busy = '0; e_irq = '0;
  endtask

  // One bus cycle: drive at negedge, advance the model over the coming edge,
  // return 1 time unit after that edge.
  task automatic bus_cycle(input logic v, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bit    in_rng, bad;
    int    c, off;
    resp_t r;
    @(negedge clk);
    valid = v; wr_en = wr; addr = a; wdata = wd;
    in_rng = (a < ADDR_W'(NUM_CH * 16));
    c   = int'(a[7:4]);
    off = int'(a[3:2]);
    bad = v && (!in_rng || (wr && off != 3 && m_busy_pre(c)));
    r.v = v && !wr;
    r.e = bad;
    r.d = (r.v && !bad) ? m_read(c, off) : 32'h0;
    if (v && wr && !bad) begin
      case (off)
        0: m_src[c] = wd[31:0];
        1: m_dst[c] = wd[31:0];
        2: m_len[c] = wd[15:0];
        default: begin
          if (wd[2]) m_done[c] = 0;
          m_ie[c] = wd[3];
          if (wd[0] && !m_busy_pre(c)) begin
            if (m_len[c] != 0) m_end[c] = m_t + m_len[c];
            else m_done[c] = 1;
          end
        end
      endcase
    end
    for (int ch = 0; ch < NUM_CH; ch++) if (m_end[ch] == m_t) m_done[ch] = 1;
    m_pipe.push_back(r);
    if (m_pipe.size() > RD_LAT) void'(m_pipe.pop_front());
    e_rvalid = m_pipe[0].v;
    e_err    = m_pipe[0].e;
    e_rdata  = DATA_W'(m_pipe[0].d);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_busy[ch] = (m_t < m_end[ch]);
      e_irq[ch]  = m_done[ch] & m_ie[ch];
    end
    m_t++;
    @(posedge clk);
    #1;
    valid = 0; wr_en = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, irq, rvalid, err, rdata} !== '0)
      $display("FAIL reset_hold: got busy=%b irq=%b rv=%b err=%b rdata=%h, expected all 0",
               busy, irq, rvalid, err, rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1;
    bus_cycle(1, 0, 32'h04, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || err !== 0 || rdata !== 0 || busy !== 0 || irq !== 0)
      $display("FAIL reset_read: got rv=%b err=%b rdata=%h busy=%b irq=%b, expected rv=1 err=0 rdata=0 busy=0 irq=0",
               rvalid, err, rdata, busy, irq);
    else n_pass++;
  endtask

  task automatic test_rd_latency();
    bus_cycle(1, 1, 32'h20, 32'hDEADBEEF);
    bus_cycle(1, 0, 32'h20, 0);
    n_checks++;
    if (rvalid !== 0) $display("FAIL rdlat_early: got rvalid=%b expected 0", rvalid);
    else n_pass++;
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || err !== 0 || rdata !== 32'hDEADBEEF)
      $display("FAIL rdlat_resp: got rv=%b err=%b rdata=%h expected rv=1 err=0 rdata=deadbeef",
               rvalid, err, rdata);
    else n_pass++;
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 0 || rdata !== 0)
      $display("FAIL rdlat_after: got rv=%b rdata=%h expected rv=0 rdata=0", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_countdown();
    int rem_exp [3];
    int busy_cnt, got;
    rem_exp = '{3, 2, 1};
    bus_cycle(1, 1, 32'h08, 3);
    bus_cycle(1, 1, 32'h0C, 32'h9);
    busy_cnt = busy[0] ? 1 : 0;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) bus_cycle(1, 0, 32'h0C, 0);
      else       bus_cycle(0, 0, 0, 0);
      if (busy[0]) busy_cnt++;
      if (rvalid) begin
        n_checks++;
        if (got >= 3 || rdata[31:16] !== 16'(rem_exp[got % 3]))
          $display("FAIL countdown_remain[%0d]: got %0d expected %0d", got, rdata[31:16], rem_exp[got % 3]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (busy_cnt != 3 || got != 3)
      $display("FAIL countdown_busy: got busy cycles %0d responses %0d, expected 3 and 3", busy_cnt, got);
    else n_pass++;
    n_checks++;
    if (irq[0] !== 1) $display("FAIL countdown_irq: got irq0=%b expected 1", irq[0]);
    else n_pass++;
    bus_cycle(1, 0, 32'h0C, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || rdata !== 32'hC)
      $display("FAIL countdown_ctrl: got rv=%b rdata=%h expected rv=1 rdata=0000000c", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_len0();
    bus_cycle(1, 1, 32'h0C, 32'h4);
    n_checks++;
    if (irq[0] !== 0) $display("FAIL len0_clear: got irq0=%b expected 0", irq[0]);
    else n_pass++;
    bus_cycle(1, 1, 32'h08, 0);
    bus_cycle(1, 1, 32'h0C, 32'h9);
    n_checks++;
    if (busy[0] !== 0 || irq[0] !== 1)
      $display("FAIL len0_done: got busy0=%b irq0=%b expected busy0=0 irq0=1", busy[0], irq[0]);
    else n_pass++;
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (busy[0] !== 0) $display("FAIL len0_nobusy: got busy0=%b expected 0", busy[0]);
    else n_pass++;
    bus_cycle(1, 1, 32'h0C, 32'h4);
    n_checks++;
    if (irq[0] !== 0) $display("FAIL len0_w1c: got irq0=%b expected 0", irq[0]);
    else n_pass++;
    bus_cycle(1, 1, 32'h0C, 32'h9);
    bus_cycle(1, 1, 32'h0C, 32'h0);
    n_checks++;
    if (irq[0] !== 0) $display("FAIL ie_clear_irq: got irq0=%b expected 0", irq[0]);
    else n_pass++;
    bus_cycle(1, 0, 32'h0C, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || rdata !== 32'h4)
      $display("FAIL ie_clear_done: got rv=%b rdata=%h expected rv=1 rdata=00000004", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_collision();
    bus_cycle(1, 1, 32'h38, 3);
    bus_cycle(1, 1, 32'h3C, 32'h9);
    n_checks++;
    if (busy[3] !== 1) $display("FAIL coll_start: got busy3=%b expected 1", busy[3]);
    else n_pass++;
    bus_cycle(1, 1, 32'h3C, 32'h9);
    bus_cycle(1, 0, 32'h3C, 0);
    n_checks++;
    if (err !== 0) $display("FAIL coll_start_noerr: got err=%b expected 0", err);
    else n_pass++;
    bus_cycle(1, 1, 32'h3C, 32'hD);
    n_checks++;
    if (busy[3] !== 0 || irq[3] !== 1 || rvalid !== 1 || rdata[31:16] !== 16'd2)
      $display("FAIL coll_edge: got busy3=%b irq3=%b rv=%b remain=%0d expected busy3=0 irq3=1 rv=1 remain=2",
               busy[3], irq[3], rvalid, rdata[31:16]);
    else n_pass++;
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (busy[3] !== 0) $display("FAIL coll_norestart: got busy3=%b expected 0", busy[3]);
    else n_pass++;
    bus_cycle(1, 0, 32'h3C, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || rdata !== 32'hC)
      $display("FAIL coll_ctrl: got rv=%b rdata=%h expected rv=1 rdata=0000000c", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_bad();
    bus_cycle(1, 0, 32'h40, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || err !== 1 || rdata !== 0)
      $display("FAIL bad_addr: got rv=%b err=%b rdata=%h expected rv=1 err=1 rdata=0", rvalid, err, rdata);
    else n_pass++;
    bus_cycle(1, 1, 32'h08, 5);
    bus_cycle(1, 1, 32'h0C, 32'h1);
    bus_cycle(1, 1, 32'h08, 32'h77);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (err !== 1 || rvalid !== 0)
      $display("FAIL bad_busy_wr: got err=%b rv=%b expected err=1 rv=0", err, rvalid);
    else n_pass++;
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (err !== 0) $display("FAIL bad_pulse: got err=%b expected 0", err);
    else n_pass++;
    for (int i = 0; i < 6; i++) bus_cycle(0, 0, 0, 0);
    bus_cycle(1, 0, 32'h08, 0);
    bus_cycle(0, 0, 0, 0);
    n_checks++;
    if (rvalid !== 1 || rdata !== 32'h5)
      $display("FAIL bad_len_kept: got rv=%b rdata=%h expected rv=1 rdata=00000005", rvalid, rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [NUM_CH];
    for (int c = 0; c < NUM_CH; c++) begin
      vals[c] = $urandom;
      bus_cycle(1, 1, ADDR_W'(c * 16), vals[c]);
    end
    for (int i = 0; i < NUM_CH + RD_LAT - 1; i++) begin
      if (i < NUM_CH) bus_cycle(1, 0, ADDR_W'(i * 16), 0);
      else            bus_cycle(0, 0, 0, 0);
      if (i >= RD_LAT - 1) begin
        n_checks++;
        if (rvalid !== 1 || err !== 0 || rdata !== vals[i - RD_LAT + 1])
          $display("FAIL b2b[%0d]: got rv=%b err=%b rdata=%h expected rv=1 err=0 rdata=%h",
                   i, rvalid, err, rdata, vals[i - RD_LAT + 1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int kind;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int n = 0; n < 800; n++) begin
      kind = int'($urandom_range(0, 99));
      a = ADDR_W'($urandom_range(0, NUM_CH * 4 - 1) * 4);
      d = $urandom;
      if (a[3:2] == 2'd2) d = DATA_W'($urandom_range(0, 6));
      if (kind < 3) a = ADDR_W'($urandom_range(NUM_CH * 16, NUM_CH * 16 + 63));
      else if (kind < 5) a = $urandom;
      a[1:0] = 2'($urandom_range(0, 3));
      if (kind >= 5 && kind < 30) bus_cycle(0, 0, a, d);
      else if (kind < 65)         bus_cycle(1, 0, a, d);
      else                        bus_cycle(1, 1, a, d);
      n_checks++;
      if ({rvalid, err, rdata, busy, irq} !== {e_rvalid, e_err, e_rdata, e_busy, e_irq})
        $display("FAIL random[%0d]: got rv=%b err=%b rdata=%h busy=%b irq=%b, expected rv=%b err=%b rdata=%h busy=%b irq=%b",
                 n, rvalid, err, rdata, busy, irq, e_rvalid, e_err, e_rdata, e_busy, e_irq);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [ADDR_W-1:0] ra [3];
    ra = '{32'h18, 32'h1C, 32'h10};
    for (int i = 0; i < 10; i++) bus_cycle(0, 0, 0, 0);
    bus_cycle(1, 1, 32'h08, 0);
    bus_cycle(1, 1, 32'h0C, 32'h9);
    bus_cycle(1, 1, 32'h18, 20);
    bus_cycle(1, 1, 32'h1C, 32'h9);
    bus_cycle(0, 0, 0, 0);
    bus_cycle(1, 0, 32'h10, 0);
    n_checks++;
    if (busy[1] !== 1 || irq[0] !== 1)
      $display("FAIL rst_pre: got busy1=%b irq0=%b expected busy1=1 irq0=1", busy[1], irq[0]);
    else n_pass++;
    #2;
    reset = 0;
    m_reset();
    #1;
    n_checks++;
    if (busy !== 0 || irq !== 0 || rvalid !== 0 || err !== 0)
      $display("FAIL rst_async: got busy=%b irq=%b rv=%b err=%b expected all 0", busy, irq, rvalid, err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (rvalid !== 0 || rdata !== 0)
      $display("FAIL rst_flush: got rv=%b rdata=%h expected rv=0 rdata=0", rvalid, rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus_cycle(1, 0, ra[i], 0);
      else       bus_cycle(0, 0, 0, 0);
      if (i >= 1) begin
        n_checks++;
        if (rvalid !== 1 || rdata !== 0 || busy !== 0)
          $display("FAIL rst_readback[%0d]: got rv=%b rdata=%h busy=%b expected rv=1 rdata=0 busy=0",
                   i, rvalid, rdata, busy);
        else n_pass++;
      end
    end
  endtask

  initial begin
    m_t = 1;
    m_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_rd_latency();
    test_countdown();
    test_len0();
    test_collision();
    test_bad();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
